dual_req_bram_arbiter: RTL and testbench

Shares one single-port BRAM (1-cycle read latency) between two independent requesters. Each requester uses the run/mode/address/write-data handshake of the single BRAM controllers and gets back idle/done/read_valid/read_data. Sits between two requester datapaths and the BRAM instance in the block design. Round-robin arbitration with one outstanding access per requester.

---
 rtl/dual_req_bram_arbiter_if.sv | 56 +++++
 rtl/dual_req_bram_arbiter.sv | 173 +++++++++++++++++
 tb/tb_dual_req_bram_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dual_req_bram_arbiter_if.sv
// Requester and BRAM-side signal bundle for dual_req_bram_arbiter.
// slave  : the arbiter's view (requester inputs in, BRAM read data in).
// master : the surrounding datapath's view (requesters plus BRAM instance).
interface dual_req_bram_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  // Requester 0
  logic                  i_run_0;
  logic                  i_mode_0;
  logic [ADDR_WIDTH-1:0] i_bramAddr_0;
  logic [DATA_WIDTH-1:0] i_write_data_0;
  logic                  o_idle_0;
  logic                  o_done_0;
  logic                  o_read_0;
  logic                  o_write_0;
  logic                  o_read_valid_0;
  logic [DATA_WIDTH-1:0] o_read_data_0;

  // Requester 1
  logic                  i_run_1;
  logic                  i_mode_1;
  logic [ADDR_WIDTH-1:0] i_bramAddr_1;
  logic [DATA_WIDTH-1:0] i_write_data_1;
  logic                  o_idle_1;
  logic                  o_done_1;
  logic                  o_read_1;
  logic                  o_write_1;
  logic                  o_read_valid_1;
  logic [DATA_WIDTH-1:0] o_read_data_1;

  // Shared single-port BRAM
  logic                  o_bram_en;
  logic                  o_bram_we;
  logic [ADDR_WIDTH-1:0] o_bram_addr;
  logic [DATA_WIDTH-1:0] o_bram_wdata;
  logic [DATA_WIDTH-1:0] i_bram_rdata;

  modport slave (
    input  i_run_0, i_mode_0, i_bramAddr_0, i_write_data_0,
    input  i_run_1, i_mode_1, i_bramAddr_1, i_write_data_1,
    input  i_bram_rdata,
    output o_idle_0, o_done_0, o_read_0, o_write_0, o_read_valid_0, o_read_data_0,
    output o_idle_1, o_done_1, o_read_1, o_write_1, o_read_valid_1, o_read_data_1,
    output o_bram_en, o_bram_we, o_bram_addr, o_bram_wdata
  );

  modport master (
    output i_run_0, i_mode_0, i_bramAddr_0, i_write_data_0,
    output i_run_1, i_mode_1, i_bramAddr_1, i_write_data_1,
    output i_bram_rdata,
    input  o_idle_0, o_done_0, o_read_0, o_write_0, o_read_valid_0, o_read_data_0,
    input  o_idle_1, o_done_1, o_read_1, o_write_1, o_read_valid_1, o_read_data_1,
    input  o_bram_en, o_bram_we, o_bram_addr, o_bram_wdata
  );
endinterface

// File: rtl/dual_req_bram_arbiter.sv
// Two-requester arbiter in front of one single-port BRAM (1-cycle read latency).
// Each requester owns a one-deep request slot; the FSM serves one slot at a
// time (IDLE -> ACCESS -> [WAIT] -> DONE) and breaks ties round-robin.
// Build option: define ARB_FIXED_PRIO_EN to make requester 0 win every tie
// (the round-robin pointer is then held at 0).
module dual_req_bram_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  dual_req_bram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_g;       // slot currently granted
  logic                  r_rr;      // tie-break winner for the next arbitration
  logic [1:0]            r_pend;
  logic [1:0]            r_mode;
  logic [ADDR_WIDTH-1:0] r_addr  [2];
  logic [DATA_WIDTH-1:0] r_wdata [2];
  logic [DATA_WIDTH-1:0] r_rdata [2];
  logic [1:0]            r_done;
  logic [1:0]            r_rvalid;

  logic [1:0]            w_run;
  logic [1:0]            w_mode;
  logic [ADDR_WIDTH-1:0] w_addr  [2];
  logic [DATA_WIDTH-1:0] w_wdata [2];
  logic                  w_retire;
  logic [1:0]            w_clear;
  logic [1:0]            w_read;
  logic [1:0]            w_write;
  logic                  w_bram_en;
  logic                  w_bram_we;
  logic [ADDR_WIDTH-1:0] w_bram_addr;
  logic [DATA_WIDTH-1:0] w_bram_wdata;

  assign w_run      = {bus.i_run_1,  bus.i_run_0};
  assign w_mode     = {bus.i_mode_1, bus.i_mode_0};
  assign w_addr[0]  = bus.i_bramAddr_0;
  assign w_addr[1]  = bus.i_bramAddr_1;
  assign w_wdata[0] = bus.i_write_data_0;
  assign w_wdata[1] = bus.i_write_data_1;

  // The granted slot empties at the edge that enters S_DONE, so its requester
  // sees o_idle during the done cycle and may re-issue immediately.
  assign w_retire   = ((r_state == S_ACCESS) && r_mode[r_g]) || (r_state == S_WAIT);
  assign w_clear[0] = w_retire && (r_g == 1'b0);
  assign w_clear[1] = w_retire && (r_g == 1'b1);

  // Request slots: capture a new request only when the slot is empty.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking (<=) throughout so every flop samples pre-edge values.
    if (reset) begin
      r_pend <= '0;
      r_mode <= '0;
      // NOTE: these capture arrays are a handful of flops, not a RAM, so they
      // are cleared with the rest of the state.
      for (int k = 0; k < 2; k++) begin
        r_addr[k]  <= '0;
        r_wdata[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (w_run[k] && !r_pend[k]) begin
          r_pend[k]  <= 1'b1;
          r_mode[k]  <= w_mode[k];
          r_addr[k]  <= w_addr[k];
          r_wdata[k] <= w_wdata[k];
        end else if (w_clear[k]) begin
          r_pend[k] <= 1'b0;
        end
      end
    end
  end

  // Arbitration FSM with registered done / read-valid / read-data outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_g      <= 1'b0;
      r_rr     <= 1'b0;
      r_done   <= '0;
      r_rvalid <= '0;
      r_rdata[0] <= '0;
      r_rdata[1] <= '0;
    end else begin
      r_done   <= '0;
      r_rvalid <= '0;
      case (r_state)
        S_IDLE: begin
          if (r_pend != 2'b00) begin
            r_state <= S_ACCESS;
            // With both pending the pointer decides; otherwise the lone one.
            r_g     <= (r_pend == 2'b11) ? r_rr : r_pend[1];
          end
        end
        S_ACCESS: begin
          if (r_mode[r_g]) begin
            r_state     <= S_DONE;
            r_done[r_g] <= 1'b1;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_state       <= S_DONE;
          r_rdata[r_g]  <= bus.i_bram_rdata;
          r_done[r_g]   <= 1'b1;
          r_rvalid[r_g] <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
`ifdef ARB_FIXED_PRIO_EN
          r_rr    <= 1'b0;
`else
          r_rr    <= ~r_g;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // BRAM bus and per-requester activity flags, decoded from state and grant.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    w_bram_en    = 1'b0;
    w_bram_we    = 1'b0;
    w_bram_addr  = '0;
    w_bram_wdata = '0;
    w_read       = '0;
    w_write      = '0;
    if (r_state == S_ACCESS) begin
      w_bram_en    = 1'b1;
      w_bram_we    = r_mode[r_g];
      w_bram_addr  = r_addr[r_g];
      w_bram_wdata = r_wdata[r_g];
      w_read[r_g]  = ~r_mode[r_g];
      w_write[r_g] = r_mode[r_g];
    end else if (r_state == S_WAIT) begin
      w_read[r_g]  = 1'b1;
    end
  end

  assign bus.o_bram_en      = w_bram_en;
  assign bus.o_bram_we      = w_bram_we;
  assign bus.o_bram_addr    = w_bram_addr;
  assign bus.o_bram_wdata   = w_bram_wdata;

  assign bus.o_idle_0       = ~r_pend[0];
  assign bus.o_done_0       = r_done[0];
  assign bus.o_read_0       = w_read[0];
  assign bus.o_write_0      = w_write[0];
  assign bus.o_read_valid_0 = r_rvalid[0];
  assign bus.o_read_data_0  = r_rdata[0];

  assign bus.o_idle_1       = ~r_pend[1];
  assign bus.o_done_1       = r_done[1];
  assign bus.o_read_1       = w_read[1];
  assign bus.o_write_1      = w_write[1];
  assign bus.o_read_valid_1 = r_rvalid[1];
  assign bus.o_read_data_1  = r_rdata[1];

endmodule

// File: tb/tb_dual_req_bram_arbiter.sv
// Scoreboard bench for dual_req_bram_arbiter: a behavioural BRAM sits on the
// bus, expected BRAM accesses and completions are queued as stimulus is
// driven and compared when the arbiter produces them.
module tb_dual_req_bram_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dual_req_bram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_if ();

  dual_req_bram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  // Behavioural single-port BRAM, read data valid one cycle after en.
  logic [DW-1:0] mem [1024];
  always @(posedge clk) begin
    if (u_if.o_bram_en) begin
      if (u_if.o_bram_we) mem[u_if.o_bram_addr] <= u_if.o_bram_wdata;
      else                u_if.i_bram_rdata     <= mem[u_if.o_bram_addr];
    end
  end

  typedef struct packed {
    logic          k;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } bus_t;

  typedef struct packed {
    logic          rd;
    logic [DW-1:0] data;
  } done_t;

  bus_t  q_bus[$];
  done_t q_done0[$];
  done_t q_done1[$];

  int total = 0;
  int bad   = 0;
  int we_cnt = 0;
  int rw0_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Queue one expected BRAM access plus its completion (data = read result for reads).
  task automatic expect_access(input logic k, input logic we, input int addr, input logic [DW-1:0] data);
    bus_t  e;
    done_t d;
    e.k = k; e.we = we; e.addr = addr[AW-1:0]; e.wdata = data;
    d.rd = ~we; d.data = data;
    q_bus.push_back(e);
    if (k) q_done1.push_back(d);
    else   q_done0.push_back(d);
  endtask

  task automatic drive(input logic k, input logic we, input int addr, input logic [DW-1:0] data);
    if (k) begin
      u_if.i_run_1 = 1'b1; u_if.i_mode_1 = we;
      u_if.i_bramAddr_1 = addr[AW-1:0]; u_if.i_write_data_1 = data;
    end else begin
      u_if.i_run_0 = 1'b1; u_if.i_mode_0 = we;
      u_if.i_bramAddr_0 = addr[AW-1:0]; u_if.i_write_data_0 = data;
    end
  endtask

  task automatic stop(input logic k);
    if (k) u_if.i_run_1 = 1'b0;
    else   u_if.i_run_0 = 1'b0;
  endtask

  // One isolated access; checks done latency counted from the run edge.
  task automatic do_single(input logic k, input logic we, input int addr,
                           input logic [DW-1:0] data, input int exp_lat);
    int cyc;
    expect_access(k, we, addr, data);
    @(negedge clk);
    drive(k, we, addr, we ? data : '0);
    @(negedge clk);
    stop(k);
    cyc = 1;
    while (!(k ? u_if.o_done_1 : u_if.o_done_0) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check(k ? "latency_1" : "latency_0", cyc, exp_lat);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q_bus.size() + q_done0.size() + q_done1.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", q_bus.size() + q_done0.size() + q_done1.size(), 0);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    check("rst_idle",  {u_if.o_idle_1, u_if.o_idle_0}, 2'b11);
    check("rst_flags", {u_if.o_done_0, u_if.o_done_1, u_if.o_read_valid_0, u_if.o_read_valid_1,
                        u_if.o_read_0, u_if.o_read_1, u_if.o_write_0, u_if.o_write_1}, 8'h00);
    check("rst_rdata", {u_if.o_read_data_1, u_if.o_read_data_0}, 64'h0);
    check("rst_bram",  {u_if.o_bram_en, u_if.o_bram_we, 22'(u_if.o_bram_addr)}, 24'h0);
    check("rst_wdata", u_if.o_bram_wdata, 0);
  endtask

  task automatic done_mon(input logic k, input logic dn, input logic rv, input logic [DW-1:0] rd);
    done_t d;
    if (dn) begin
      if ((k ? q_done1.size() : q_done0.size()) == 0) begin
        check(k ? "done_unexpected_1" : "done_unexpected_0", 1, 0);
      end else begin
        d = k ? q_done1.pop_front() : q_done0.pop_front();
        check(k ? "rvalid_1" : "rvalid_0", rv, d.rd);
        if (d.rd) check(k ? "rdata_1" : "rdata_0", rd, d.data);
      end
    end else if (rv) begin
      check(k ? "rvalid_no_done_1" : "rvalid_no_done_0", 1, 0);
    end
  endtask

  // Monitor: compare every BRAM access and every completion against the queues.
  bus_t       m_e;
  logic [3:0] m_rw;
  always @(negedge clk) begin
    if (!reset) begin
      if (u_if.o_bram_en) begin
        if (u_if.o_bram_we) we_cnt++;
        if (q_bus.size() == 0) begin
          check("bus_unexpected", 1, 0);
        end else begin
          m_e = q_bus.pop_front();
          m_rw = m_e.k ? {~m_e.we, m_e.we, 2'b00} : {2'b00, ~m_e.we, m_e.we};
          check("bus_we",   u_if.o_bram_we, m_e.we);
          check("bus_addr", u_if.o_bram_addr, m_e.addr);
          if (m_e.we) check("bus_wdata", u_if.o_bram_wdata, m_e.wdata);
          check("bus_owner", {u_if.o_read_1, u_if.o_write_1, u_if.o_read_0, u_if.o_write_0}, m_rw);
        end
      end else begin
        check("bus_quiet", (u_if.o_bram_we || u_if.o_bram_addr != '0 || u_if.o_bram_wdata != '0), 0);
      end
      if (u_if.o_read_0 || u_if.o_write_0) rw0_cnt++;
      done_mon(1'b0, u_if.o_done_0, u_if.o_read_valid_0, u_if.o_read_data_0);
      done_mon(1'b1, u_if.o_done_1, u_if.o_read_valid_1, u_if.o_read_data_1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int iss0;
    int iss1;
    int n;
    u_if.i_run_0 = 1'b0; u_if.i_mode_0 = 1'b0; u_if.i_bramAddr_0 = '0; u_if.i_write_data_0 = '0;
    u_if.i_run_1 = 1'b0; u_if.i_mode_1 = 1'b0; u_if.i_bramAddr_1 = '0; u_if.i_write_data_1 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;

    // 1: requester 0 writes addr 0..9 with data = addr
    for (int a = 0; a < 10; a++) do_single(1'b0, 1'b1, a, DW'(a), 3);
    drain(10);
    check("t1_we_cycles", we_cnt, 10);

    // 2: requester 1 reads them back; requester 0 flags stay low
    base = rw0_cnt;
    for (int a = 1; a < 10; a++) do_single(1'b1, 1'b0, a, DW'(a), 4);
    drain(10);
    check("t2_rw0_quiet", rw0_cnt - base, 0);
    check("t2_rdata_hold", u_if.o_read_data_1, 9);

    // 3a: simultaneous write/read of addr 5, pointer at 0 -> write first
    expect_access(1'b0, 1'b1, 5, 32'hA5);
    expect_access(1'b1, 1'b0, 5, 32'hA5);
    @(negedge clk);
    drive(1'b0, 1'b1, 5, 32'hA5);
    drive(1'b1, 1'b0, 5, 0);
    @(negedge clk);
    stop(1'b0); stop(1'b1);
    drain(40);

    // 3b: restore addr 5 via requester 0 (pointer -> 1), then collide again
    do_single(1'b0, 1'b1, 5, 32'd5, 3);
    drain(10);
`ifdef ARB_FIXED_PRIO_EN
    expect_access(1'b0, 1'b1, 5, 32'hA5);
    expect_access(1'b1, 1'b0, 5, 32'hA5);
`else
    expect_access(1'b1, 1'b0, 5, 32'd5);
    expect_access(1'b0, 1'b1, 5, 32'hA5);
`endif
    @(negedge clk);
    drive(1'b0, 1'b1, 5, 32'hA5);
    drive(1'b1, 1'b0, 5, 0);
    @(negedge clk);
    stop(1'b0); stop(1'b1);
    drain(40);

    // 4: both requesters continuously requesting, four reads each
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      expect_access(1'b0, 1'b0, 2, 32'd2);
`else
      expect_access(1'b1, 1'b0, 4, 32'd4);
      expect_access(1'b0, 1'b0, 2, 32'd2);
`endif
    end
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) expect_access(1'b1, 1'b0, 4, 32'd4);
`endif
    iss0 = 0; iss1 = 0; n = 0;
    while ((iss0 < 4 || iss1 < 4 || (q_bus.size() + q_done0.size() + q_done1.size()) != 0) && n < 200) begin
      @(negedge clk);
      n++;
      if (iss0 < 4 && u_if.o_idle_0) begin
        drive(1'b0, 1'b0, 2, 0);
        iss0++;
      end else begin
        stop(1'b0);
      end
      if (iss1 < 4) begin
        drive(1'b1, 1'b0, 4, 0);
        if (u_if.o_idle_1) iss1++;
      end else begin
        stop(1'b1);
      end
    end
    stop(1'b0); stop(1'b1);
    check("t4_issued", {iss0[7:0], iss1[7:0]}, {8'd4, 8'd4});
    drain(10);

    // 5: second run while slot 0 pending is ignored
    expect_access(1'b0, 1'b1, 6, 32'h66);
    @(negedge clk);
    drive(1'b0, 1'b1, 6, 32'h66);
    @(negedge clk);
    check("t5_pending", u_if.o_idle_0, 1'b0);
    drive(1'b0, 1'b1, 7, 32'h77);
    @(negedge clk);
    stop(1'b0);
    drain(20);
    do_single(1'b1, 1'b0, 7, 32'd7, 4);
    do_single(1'b1, 1'b0, 6, 32'h66, 4);
    drain(10);

    // 6: reset during the access cycle of a write to addr 3
    m_e.k = 1'b0; m_e.we = 1'b1; m_e.addr = 10'd3; m_e.wdata = 32'h33;
    q_bus.push_back(m_e);
    @(negedge clk);
    drive(1'b0, 1'b1, 3, 32'h33);
    @(negedge clk);
    stop(1'b0);
    @(negedge clk);
    check("t6_in_access", u_if.o_bram_en, 1'b1);
    #2 reset = 1'b1;
    #1 check("t6_en_dropped", u_if.o_bram_en, 1'b0);
    check_reset_outputs();
    @(negedge clk);
    reset = 1'b0;
    do_single(1'b1, 1'b0, 3, 32'd3, 4);
    drain(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
